e_mdu_issue: RTL and testbench
==============================

// Module: e_mdu_issue
// PURPOSE
//  E-stage issue/hazard front-end for e_mdu. Decodes mduOp arriving from the D/E pipeline
//  register, produces the single-cycle start pulse and issues each mult/div exactly once.
//  Keeps a shadow countdown of the multiply/divide in flight, stalls D-stage HI/LO-class
//  instructions, and selects the mfhi/mflo read data.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after start for mult/multu; must equal the e_mdu latency
//  DIV_CYCLES   10  busy cycles after start for div/divu; must equal the e_mdu latency
//  CNT_W        4   shadow counter width; must hold DIV_CYCLES
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  e_mduOp      in   4   mduOp of E-stage instruction (def.v mudOp_* codes)
//  e_valid      in   1   E-stage slot holds a real instruction (0 = bubble)
//  e_hold       in   1   E stage frozen this cycle (same instruction re-presented next cycle)
//  e_flush      in   1   kill E-stage instruction this cycle
//  d_is_md      in   1   D-stage instr is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
//  mdu_busy     in   1   busy from e_mdu
//  mdu_hi       in   32  hi from e_mdu
//  mdu_lo       in   32  lo from e_mdu
//  mdu_start    out  1   start to e_mdu (combinational)
//  stall_md     out  1   to hazard unit: freeze F/D, bubble into E (combinational)
//  md_rd_data   out  32  mfhi -> mdu_hi, mflo -> mdu_lo, otherwise 0 (combinational)
//  sync_err     out  1   sticky: shadow busy disagreed with mdu_busy
// BEHAVIOUR
//  - Reset: cnt=0, issued=0, sync_err=0. mdu_start=0 and stall_md=0 while reset=1.
//  - is_muldiv = e_mduOp in {mult,multu,div,divu}. is_mt = e_mduOp in {mthi,mtlo}.
//  - mdu_start = e_valid & ~e_flush & ~issued & (is_muldiv | is_mt) & (cnt==0).
//    mthi/mtlo pulse start as well; e_mdu writes them on the start cycle.
//  - issued: set when mdu_start=1 & e_hold=1; cleared on any cycle with e_hold=0.
//    A held instruction therefore never restarts the MDU.
//  - Shadow counter, registered:
//    - start & mult/multu: cnt <= MULT_CYCLES.
//    - start & div/divu: cnt <= DIV_CYCLES.
//    - else if cnt!=0: cnt <= cnt-1.
//    - Start at edge T: shadow busy (cnt!=0) is high for cycles T+1..T+N. HI/LO hold the
//      new result from T+N+1.
//  - States: IDLE (cnt==0), RUN (cnt!=0). A start in RUN is impossible by construction:
//    the mdu_start gate requires cnt==0.
//  - stall_md = d_is_md & (mdu_start | cnt!=0 | mdu_busy).
//    - Covers the start cycle, where mdu_busy is still 0.
//    - mfhi/mflo in D never sees a stale HI/LO.
//    - mthi/mtlo is never dropped by a busy e_mdu.
//  - Back-to-back MD instructions (mult in E, mult in D): D stalls for the start cycle plus
//    the N busy cycles. It enters E in cycle T+N+1.
//  - e_flush: blocks issue only. An op already started is not aborted; cnt keeps counting.
//  - e_flush and e_hold together: flush wins, no start, issued cleared on the next non-hold
//    cycle.
//  - sync_err: set at a clock edge when (cnt!=0) != mdu_busy, outside the start cycle. Only
//    reset clears it.
//  - Reset mid-operation: cnt and issued return to 0 in one cycle. e_mdu resets at the same
//    edge, so both are idle at the next cycle.
//  - md_rd_data is pure mux. Data is valid whenever stall_md=0 for the reading instruction.
// STRUCTURE
//  - def.v (shared include): mudOp_* codes, including mudOp_mfhi/mudOp_mflo,
//    `MDU_MULT_CYCLES 5, `MDU_DIV_CYCLES 10.
//  - Single module; no sub-module. Op-class decode is inline combinational logic.
// TESTING
//  1. mult valid in E at cycle T, d_is_md=1:
//     mdu_start=1 at T; stall_md=1 at T..T+5; stall_md=0 at T+6; md_rd_data=mdu_lo.
//  2. div in E, then mflo in D:
//     stall_md high 11 cycles (T..T+10). With d1=7, d2=2, md_rd_data=3 at T+11.
//  3. mult with e_hold=1 for 3 cycles:
//     exactly one mdu_start pulse; cnt loads 5 once.
//  4. mthi in E with cnt=0:
//     mdu_start=1, cnt stays 0; D-stage mfhi stalls 1 cycle, then reads the mthi value.
//  5. div started, e_flush on the next E instruction (mult):
//     no second start; cnt 10..0 undisturbed; sync_err=0.
//  6. reset asserted at cnt=6: cnt=0, mdu_start=0, stall_md=0 the next cycle.
//     Force mdu_busy=1 with cnt=0: sync_err=1 and it stays 1.

Source files
------------

// File: rtl/e_mdu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_issue_pkg
//  Purpose  : mduOp encodings, MDU latency defaults and op-class helpers
//  Revision : 1.0
// ============================================================================
package e_mdu_issue_pkg;

    localparam logic [3:0] c_MDUOP_NONE  = 4'd0;
    localparam logic [3:0] c_MDUOP_MULT  = 4'd1;
    localparam logic [3:0] c_MDUOP_MULTU = 4'd2;
    localparam logic [3:0] c_MDUOP_DIV   = 4'd3;
    localparam logic [3:0] c_MDUOP_DIVU  = 4'd4;
    localparam logic [3:0] c_MDUOP_MTHI  = 4'd5;
    localparam logic [3:0] c_MDUOP_MTLO  = 4'd6;
    localparam logic [3:0] c_MDUOP_MFHI  = 4'd7;
    localparam logic [3:0] c_MDUOP_MFLO  = 4'd8;

    localparam int c_MDU_MULT_CYCLES = 5;
    localparam int c_MDU_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == c_MDUOP_DIV) || (op == c_MDUOP_DIVU);
    endfunction

    function automatic logic op_is_muldiv(input logic [3:0] op);
        return (op == c_MDUOP_MULT) || (op == c_MDUOP_MULTU) || op_is_div(op);
    endfunction

    function automatic logic op_is_mt(input logic [3:0] op);
        return (op == c_MDUOP_MTHI) || (op == c_MDUOP_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_issue_if
//  Purpose  : Start/busy/result link between the issue front-end and e_mdu
//  Revision : 1.0
// ============================================================================
interface e_mdu_issue_if;
    logic        mdu_start;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;

    modport master (output mdu_start, input mdu_busy, mdu_hi, mdu_lo);
    modport slave  (input mdu_start, output mdu_busy, mdu_hi, mdu_lo);
endinterface
`default_nettype wire

// File: rtl/e_mdu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_issue
//  Purpose  : E-stage issue/hazard front-end for e_mdu: start pulse, shadow
//             busy countdown, D-stage HI/LO stall and mfhi/mflo read mux
//  Revision : 1.0
// ============================================================================
module e_mdu_issue
    import e_mdu_issue_pkg::*;
#(
    parameter int MULT_CYCLES = c_MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = c_MDU_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [3:0]        e_mduOp,
    input  wire logic              e_valid,
    input  wire logic              e_hold,
    input  wire logic              e_flush,
    input  wire logic              d_is_md,
    e_mdu_issue_if.master          mdu,
    output logic                   stall_md,
    output logic [31:0]            md_rd_data,
    output logic                   sync_err
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_issued;
    logic             r_sync_err;
    mdu_state_t       r_state;

    logic w_is_muldiv;
    logic w_is_mt;
    logic w_is_div;
    logic w_shadow_busy;
    logic w_start;

    assign w_is_muldiv   = op_is_muldiv(e_mduOp);
    assign w_is_mt       = op_is_mt(e_mduOp);
    assign w_is_div      = op_is_div(e_mduOp);
    assign w_shadow_busy = (r_state == ST_RUN);

    // The idle gate alone makes a start during RUN impossible.
    assign w_start = ~reset & e_valid & ~e_flush & ~r_issued
                   & (w_is_muldiv | w_is_mt) & ~w_shadow_busy;

    assign mdu.mdu_start = w_start;

    // Start cycle is included because e_mdu has not raised busy yet.
    assign stall_md = ~reset & d_is_md & (w_start | w_shadow_busy | mdu.mdu_busy);

    assign sync_err = r_sync_err;

    always_comb begin
        md_rd_data = 32'd0;
        case (e_mduOp)
            c_MDUOP_MFHI: md_rd_data = mdu.mdu_hi;
            c_MDUOP_MFLO: md_rd_data = mdu.mdu_lo;
            default:      md_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_issued   <= 1'b0;
            r_sync_err <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            // A held instruction must not restart the MDU on re-presentation.
            if (!e_hold) begin
                r_issued <= 1'b0;
            end else if (w_start) begin
                r_issued <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start && w_is_muldiv) begin
                        r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (!w_start && (w_shadow_busy != mdu.mdu_busy)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_mdu_issue
//  Purpose  : Directed self-checking bench for e_mdu_issue with a small e_mdu
//             behavioural model (5-cycle mult, 10-cycle div, mthi/mtlo on start)
//  Revision : 1.0
// ============================================================================
module tb_e_mdu_issue;
    import e_mdu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_mduOp;
    logic        e_valid, e_hold, e_flush, d_is_md;
    logic        stall_md, sync_err;
    logic [31:0] md_rd_data;

    logic [31:0] op_a, op_b;
    logic        force_busy;
    logic [3:0]  m_cnt;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          start_cnt;
    int          s0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    e_mdu_issue_if mdu_if ();

    e_mdu_issue #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .e_mduOp    (e_mduOp),
        .e_valid    (e_valid),
        .e_hold     (e_hold),
        .e_flush    (e_flush),
        .d_is_md    (d_is_md),
        .mdu        (mdu_if),
        .stall_md   (stall_md),
        .md_rd_data (md_rd_data),
        .sync_err   (sync_err)
    );

    // e_mdu stand-in: busy for N cycles after start, HI/LO updated at the last busy edge
    assign mdu_if.mdu_busy = (m_cnt != 4'd0) | force_busy;
    assign mdu_if.mdu_hi   = m_hi;
    assign mdu_if.mdu_lo   = m_lo;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 4'd0;
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
        end else if (mdu_if.mdu_start) begin
            start_cnt <= start_cnt + 1;
            case (e_mduOp)
                c_MDUOP_MULT, c_MDUOP_MULTU: begin
                    m_cnt          <= 4'd5;
                    {m_phi, m_plo} <= 64'(op_a) * 64'(op_b);
                end
                c_MDUOP_DIV, c_MDUOP_DIVU: begin
                    m_cnt <= 4'd10;
                    m_phi <= op_a % op_b;
                    m_plo <= op_a / op_b;
                end
                c_MDUOP_MTHI: m_hi <= op_a;
                c_MDUOP_MTLO: m_lo <= op_a;
                default: ;
            endcase
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic v, input logic h,
                         input logic f, input logic dmd);
        e_mduOp = op;
        e_valid = v;
        e_hold  = h;
        e_flush = f;
        d_is_md = dmd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start_cnt  = 0;
        reset      = 1'b1;
        force_busy = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd1;
        drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();

        // Reset: outputs held low even with a startable op presented
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("rst_start", 32'(mdu_if.mdu_start), 32'd0);
        check("rst_stall", 32'(stall_md), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);

        cyc();
        reset = 1'b0;
        drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        smp();
        check("idle_stall", 32'(stall_md), 32'd0);
        check("idle_rd_none", md_rd_data, 32'd0);

        // 1. mult: start at T, stall T..T+5, free at T+6
        cyc();
        op_a = 32'h0001_0000;
        op_b = 32'h0003_0005;
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t1_start", 32'(mdu_if.mdu_start), 32'd1);
        check("t1_stall_T", 32'(stall_md), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
            smp();
            check($sformatf("t1_stall_T+%0d", i), 32'(stall_md), 32'd1);
        end
        cyc();
        drive(c_MDUOP_MFLO, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t1_stall_T+6", 32'(stall_md), 32'd0);
        check("t1_mflo", md_rd_data, 32'h0005_0000);
        cyc();
        drive(c_MDUOP_MFHI, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("t1_mfhi", md_rd_data, 32'h0000_0003);

        // 2. div 7/2 with mflo waiting in D: stall T..T+10
        cyc();
        op_a = 32'd7;
        op_b = 32'd2;
        drive(c_MDUOP_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t2_start", 32'(mdu_if.mdu_start), 32'd1);
        check("t2_stall_T", 32'(stall_md), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
            smp();
            check($sformatf("t2_stall_T+%0d", i), 32'(stall_md), 32'd1);
        end
        cyc();
        drive(c_MDUOP_MFLO, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t2_stall_T+11", 32'(stall_md), 32'd0);
        check("t2_mflo", md_rd_data, 32'd3);
        cyc();
        drive(c_MDUOP_MFHI, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("t2_mfhi", md_rd_data, 32'd1);

        // 3. mult held for 3 cycles: one start, 5-cycle busy window only
        cyc();
        op_a = 32'd3;
        op_b = 32'd4;
        s0   = start_cnt;
        drive(c_MDUOP_MULT, 1'b1, 1'b1, 1'b0, 1'b1);
        smp();
        check("t3_start_T", 32'(mdu_if.mdu_start), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            cyc();
            smp();
            check($sformatf("t3_nostart_T+%0d", i), 32'(mdu_if.mdu_start), 32'd0);
        end
        cyc();
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t3_nostart_T+3", 32'(mdu_if.mdu_start), 32'd0);
        check("t3_stall_T+3", 32'(stall_md), 32'd1);
        for (int i = 4; i <= 5; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
            smp();
            check($sformatf("t3_stall_T+%0d", i), 32'(stall_md), 32'd1);
        end
        cyc();
        drive(c_MDUOP_MFLO, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t3_stall_T+6", 32'(stall_md), 32'd0);
        check("t3_mflo", md_rd_data, 32'd12);
        check("t3_start_count", 32'(start_cnt - s0), 32'd1);

        // 3b. mthi held at cnt=0: only the issued flag prevents repeats
        cyc();
        op_a = 32'h0000_ABCD;
        s0   = start_cnt;
        drive(c_MDUOP_MTHI, 1'b1, 1'b1, 1'b0, 1'b0);
        smp();
        check("t3b_start", 32'(mdu_if.mdu_start), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            cyc();
            smp();
            check($sformatf("t3b_nostart_%0d", i), 32'(mdu_if.mdu_start), 32'd0);
        end
        cyc();
        drive(c_MDUOP_MTHI, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("t3b_nostart_rel", 32'(mdu_if.mdu_start), 32'd0);
        cyc();
        drive(c_MDUOP_MFHI, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t3b_mfhi", md_rd_data, 32'h0000_ABCD);
        check("t3b_stall", 32'(stall_md), 32'd0);
        check("t3b_start_count", 32'(start_cnt - s0), 32'd1);

        // 4. mthi at cnt=0: 1-cycle stall of mfhi, then reads new HI
        cyc();
        op_a = 32'h0000_1234;
        drive(c_MDUOP_MTHI, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t4_start", 32'(mdu_if.mdu_start), 32'd1);
        check("t4_stall", 32'(stall_md), 32'd1);
        cyc();
        drive(c_MDUOP_MFHI, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t4_stall_next", 32'(stall_md), 32'd0);
        check("t4_mfhi", md_rd_data, 32'h0000_1234);

        // 5. div, then flushed mult: counter undisturbed
        cyc();
        op_a = 32'd100;
        op_b = 32'd7;
        drive(c_MDUOP_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("t5_start", 32'(mdu_if.mdu_start), 32'd1);
        check("t5_nostall_nomd", 32'(stall_md), 32'd0);
        cyc();
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b1, 1'b1);
        smp();
        check("t5_flush_nostart", 32'(mdu_if.mdu_start), 32'd0);
        check("t5_stall_T+1", 32'(stall_md), 32'd1);
        for (int i = 2; i <= 10; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
            smp();
            check($sformatf("t5_stall_T+%0d", i), 32'(stall_md), 32'd1);
        end
        cyc();
        drive(c_MDUOP_MFLO, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t5_stall_T+11", 32'(stall_md), 32'd0);
        check("t5_mflo", md_rd_data, 32'd14);
        check("t5_sync_err", 32'(sync_err), 32'd0);

        // Flush at cnt=0, alone and with hold: no start, issued stays clear
        cyc();
        op_a = 32'd2;
        op_b = 32'd2;
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b1, 1'b0);
        smp();
        check("flush_idle_nostart", 32'(mdu_if.mdu_start), 32'd0);
        cyc();
        drive(c_MDUOP_MULT, 1'b1, 1'b1, 1'b1, 1'b0);
        smp();
        check("flush_hold_nostart", 32'(mdu_if.mdu_start), 32'd0);
        cyc();
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("after_flush_start", 32'(mdu_if.mdu_start), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 6. reset while the shadow counter is at 6
        cyc();
        op_a = 32'd50;
        op_b = 32'd5;
        drive(c_MDUOP_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t6_start", 32'(mdu_if.mdu_start), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        cyc();
        reset = 1'b1;
        drive(c_MDUOP_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
        smp();
        check("t6_rst_start", 32'(mdu_if.mdu_start), 32'd0);
        check("t6_rst_stall", 32'(stall_md), 32'd0);
        cyc();
        reset = 1'b0;
        drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        smp();
        check("t6_post_rst_stall", 32'(stall_md), 32'd0);
        cyc();
        drive(c_MDUOP_MULT, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("t6_post_rst_start", 32'(mdu_if.mdu_start), 32'd1);
        check("t6_sync_err_clean", 32'(sync_err), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            drive(c_MDUOP_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Forced busy with an idle shadow counter sets the sticky error
        cyc();
        force_busy = 1'b1;
        smp();
        check("sync_err_pre", 32'(sync_err), 32'd0);
        cyc();
        force_busy = 1'b0;
        smp();
        check("sync_err_set", 32'(sync_err), 32'd1);
        cyc();
        cyc();
        smp();
        check("sync_err_sticky", 32'(sync_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
